// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin owner arbitration for one shared 4:1 datapath mux.
//
// Four requesters (CPU, GPIO, FACT, spare) compete for the mux. The winner
// owns the mux until it drops its request, or until it has held the mux for
// MAX_HOLD cycles while someone else is waiting. Between any two owners there
// is exactly one turnaround cycle with no grant, so the mux select never moves
// under an active owner.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   req      in   [3:0] per-requester request, held for the whole transaction
//   gnt      out  [3:0] registered one-hot grant, zero when no owner
//   sel      out  [1:0] registered mux select, changes only when a new owner starts
//   busy     out  high while any grant bit is set
//   timeout  out  one-cycle pulse when the owner is cut off by the hold limit

// Per-requester priority lane: this requester wins if it is requesting and
// no requester closer to the rotating pointer is requesting.
module rr_mux_arbiter_lane #(
  parameter int NUM_LANES = 4,
  parameter int PTR_W     = 2,
  parameter int IDX       = 0
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic                 win
);
  logic [PTR_W-1:0] dist_self;

  // Distance from the pointer, wrapping naturally in PTR_W bits.
  assign dist_self = PTR_W'(IDX) - ptr;

  always_comb begin
    logic [PTR_W-1:0] dist_other;
    win = req[IDX];
    for (int j = 0; j < NUM_LANES; j++) begin
      dist_other = PTR_W'(j) - ptr;
      if (req[j] && (dist_other < dist_self)) win = 1'b0;
    end
  end
endmodule

module rr_mux_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);
  localparam int NUM_LANES = 4;
  localparam int PTR_W     = 2;

  localparam bit               LIMIT_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  // With the limit disabled the counter just parks at all-ones.
  localparam logic [CNT_W-1:0] CNT_SAT  = LIMIT_EN ? HOLD_LIM : {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_LANES-1:0]   gnt_q,   gnt_d;
  logic [PTR_W-1:0]       sel_q,   sel_d;
  logic [PTR_W-1:0]       ptr_q,   ptr_d;
  logic [CNT_W-1:0]       cnt_q,   cnt_d;
  logic                   timeout_q, timeout_d;

  logic [NUM_LANES-1:0]   win;
  logic [PTR_W-1:0]       win_idx;

  // Rotating-priority scan, one lane per requester.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    rr_mux_arbiter_lane #(
      .NUM_LANES (NUM_LANES),
      .PTR_W     (PTR_W),
      .IDX       (i)
    ) u_lane (
      .req (req),
      .ptr (ptr_q),
      .win (win[i])
    );
  end

  // win is one-hot or zero, so a simple priority encode is exact.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (win[i]) win_idx = PTR_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE, S_GAP: begin
        gnt_d   = '0;
        state_d = S_IDLE;
        if (|req) begin
          state_d = S_OWN;
          gnt_d   = win;
          sel_d   = win_idx;
          cnt_d   = CNT_W'(1);
        end
      end
      S_OWN: begin
        if (!req[sel_q]) begin
          // Release wins over a coincident limit hit: no timeout pulse.
          state_d = S_GAP;
          gnt_d   = '0;
          ptr_d   = sel_q + PTR_W'(1);
          cnt_d   = '0;
        end else if (LIMIT_EN && (cnt_q == HOLD_LIM) && (|(req & ~gnt_q))) begin
          state_d   = S_GAP;
          gnt_d     = '0;
          ptr_d     = sel_q + PTR_W'(1);
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = |gnt_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (MAX_HOLD=16). Inputs change 1ns after
// a rising edge; outputs are checked at that same point, away from the edge.
module tb_rr_mux_arbiter;
  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int n_chk = 0;
  int n_err = 0;

  rr_mux_arbiter #(.MAX_HOLD(16), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  // Structural invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv_busy",   {31'd0, busy}, {31'd0, |gnt});
      chk("inv_onehot", {31'd0, $onehot0(gnt)}, 32'd1);
      if (busy) chk("inv_gnt_sel", {31'd0, gnt[sel]}, 32'd1);
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;

    // Reset held with all requests asserted.
    step();
    step();
    chk("rst_gnt",  {28'd0, gnt}, 32'h0);
    chk("rst_sel",  {30'd0, sel}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_to",   {31'd0, timeout}, 32'h0);
    rst_n = 1'b1;
    step();
    chk("rst_first_gnt", {28'd0, gnt}, 32'h1);
    chk("rst_first_sel", {30'd0, sel}, 32'h0);
    // Asynchronous reset mid-ownership, well before the next edge.
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_gnt",  {28'd0, gnt}, 32'h0);
    chk("async_busy", {31'd0, busy}, 32'h0);
    req   = 4'b0000;
    #1;
    rst_n = 1'b1;

    // Single requester.
    step();
    req = 4'b0100;
    step();
    chk("single_gnt",  {28'd0, gnt}, 32'h4);
    chk("single_sel",  {30'd0, sel}, 32'h2);
    chk("single_busy", {31'd0, busy}, 32'h1);
    step();
    step();
    chk("single_hold", {28'd0, gnt}, 32'h4);
    req = 4'b0000;
    step();
    chk("single_gap_gnt", {28'd0, gnt}, 32'h0);
    chk("single_gap_sel", {30'd0, sel}, 32'h2);
    chk("single_gap_to",  {31'd0, timeout}, 32'h0);
    step();
    chk("single_idle_gnt", {28'd0, gnt}, 32'h0);
    chk("single_idle_sel", {30'd0, sel}, 32'h2);

    // Round-robin: each owner holds two cycles, drops, re-raises in GAP.
    do_reset();
    req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      int o;
      o = k % 4;
      chk("rr_gnt", {28'd0, gnt}, 32'(1 << o));
      chk("rr_sel", {30'd0, sel}, 32'(o));
      if (k < 4) begin
        step();
        chk("rr_gnt2", {28'd0, gnt}, 32'(1 << o));
        req[o] = 1'b0;
        step();
        chk("rr_gap", {28'd0, gnt}, 32'h0);
        req = 4'b1111;
        step();
      end
    end
    req = 4'b0000;
    step();
    step();

    // Hold limit: req0 permanent, req1 joins at cycle 5.
    do_reset();
    req = 4'b0001;
    for (int c = 1; c <= 16; c++) begin
      if (c == 5) req = 4'b0011;
      step();
      chk("to_own_gnt", {28'd0, gnt}, 32'h1);
      chk("to_own_to",  {31'd0, timeout}, 32'h0);
    end
    step();
    chk("to_pulse",     {31'd0, timeout}, 32'h1);
    chk("to_pulse_gnt", {28'd0, gnt}, 32'h0);
    chk("to_pulse_sel", {30'd0, sel}, 32'h0);
    step();
    chk("to_next_gnt", {28'd0, gnt}, 32'h2);
    chk("to_next_sel", {30'd0, sel}, 32'h1);
    chk("to_next_to",  {31'd0, timeout}, 32'h0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("to_req1_hold", {28'd0, gnt}, 32'h2);
    end
    req = 4'b0001;
    step();
    chk("to_rel_gap", {28'd0, gnt}, 32'h0);
    chk("to_rel_to",  {31'd0, timeout}, 32'h0);
    step();
    chk("to_back_gnt", {28'd0, gnt}, 32'h1);
    chk("to_back_sel", {30'd0, sel}, 32'h0);

    // Lone holder never times out.
    do_reset();
    req = 4'b1000;
    for (int c = 0; c < 100; c++) begin
      step();
      chk("lone_gnt", {28'd0, gnt}, 32'h8);
      chk("lone_to",  {31'd0, timeout}, 32'h0);
    end
    chk("lone_cnt_sat", {24'd0, dut.cnt_q}, 32'd16);

    // Owner releases on the same edge the limit is reached.
    do_reset();
    req = 4'b0001;
    for (int c = 1; c <= 16; c++) begin
      if (c == 3) req = 4'b0101;
      step();
      chk("co_own_gnt", {28'd0, gnt}, 32'h1);
    end
    req = 4'b0100;
    step();
    chk("co_gap_gnt", {28'd0, gnt}, 32'h0);
    chk("co_gap_to",  {31'd0, timeout}, 32'h0);
    step();
    chk("co_next_gnt", {28'd0, gnt}, 32'h4);
    chk("co_next_sel", {30'd0, sel}, 32'h2);
    chk("co_next_to",  {31'd0, timeout}, 32'h0);

    req = 4'b0000;
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 datapath mux (for example, the write-back/bus source mux) among four requesters: CPU, GPIO, FACT accelerator and one spare.
- Produces the 2-bit mux select and a one-hot grant, with a hold-time limit and a one-cycle turnaround between owners.
- Sits beside the shared mux. Its `sel` output drives the mux `s` input directly.

Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles while another requester waits. 0 disables the limit. Otherwise the legal range is 2..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request per requester. Held high for the whole transaction. Dropping it releases the resource.
- gnt  output  4  one-hot grant, registered. All zero when no owner.
- sel  output  2  mux select, registered. Equals the owner index while granted. Holds the last owner value when idle or in turnaround.
- busy  output  1  high while any gnt bit is set.
- timeout  output  1  one-cycle pulse when an owner is preempted by MAX_HOLD.

Behaviour:
- Reset (asserted asynchronously, released synchronously to clk):
  - gnt=0, sel=0, busy=0, timeout=0.
  - Priority pointer ptr=0, hold counter=0, state=IDLE.
  - Asserting rst_n low mid-ownership clears all outputs immediately, without waiting for clk.
- States: IDLE, OWN, GAP.
- Arbitration function:
  - Scan req starting at index ptr, wrapping 3->0.
  - The first set bit wins.
  - ptr is 2 bits and wraps naturally.
- IDLE:
  - If req!=0, arbitrate at the edge. At that same edge: gnt=onehot(winner), sel=winner, busy=1, counter=1, go to OWN.
  - Grant latency: req sampled at edge N, gnt visible after edge N. Zero extra cycles.
- OWN (each edge):
  - Release: if req[owner]==0, go to GAP; gnt=0; busy=0; ptr=owner+1; counter=0; timeout=0.
  - Preempt: else if MAX_HOLD!=0, and counter==MAX_HOLD, and (req & ~gnt)!=0, go to GAP; gnt=0; busy=0; ptr=owner+1; counter=0; timeout=1 for exactly this one cycle.
  - Otherwise stay in OWN; counter increments, saturating at MAX_HOLD.
  - A lone requester never times out; it keeps the grant indefinitely.
- GAP:
  - Exactly one cycle with gnt=0. This is the turnaround so the mux never switches under an active owner.
  - Next edge: if req!=0, arbitrate from the new ptr and enter OWN, same as IDLE. Otherwise go to IDLE.
  - The preempted owner may keep req high. It then re-competes at its new lowest-priority position.
- sel rules:
  - sel changes only on entry to OWN.
  - It is stable in GAP and IDLE.
  - It is never X after reset.
- Simultaneous events:
  - Owner drops req on the same edge the limit is hit: treated as a release, timeout=0.
  - Requests arriving during GAP are considered at the GAP exit edge.
- Invariants:
  - gnt is one-hot or zero.
  - busy == |gnt.
  - gnt[sel]==1 whenever busy.
  - timeout implies the next cycle is GAP.

Test Plan:
- Reset: hold rst_n=0, drive req=4'b1111 -> gnt=0, sel=0, busy=0. Release rst_n, then one edge -> gnt=4'b0001, sel=0. Pull rst_n low mid-OWN -> gnt=0 asynchronously, before the next clk.
- Single requester: req=4'b0100 at edge 0 -> gnt=4'b0100, sel=2, busy=1 after edge 0. Drop req at edge 3 -> gnt=0 (GAP). Next edge -> IDLE, sel stays 2.
- Round-robin: req=4'b1111, each owner drops req after 2 grant cycles then re-raises it during GAP -> grant order 0,1,2,3,0 with one gnt=0 cycle between owners.
- Timeout, MAX_HOLD=16:
  - req0 held permanently, req1 raised at cycle 5.
  - Expected: gnt=4'b0001 for 16 cycles, then timeout=1 for one cycle with gnt=0, then gnt=4'b0010, sel=1.
  - req0 regains the grant only after req1 drops.
- Lone holder: req=4'b1000 held for 100 cycles -> gnt=4'b1000 throughout, timeout never asserts, counter saturates at 16.
- Coincident release and limit: owner 0 drops req on the exact cycle the counter reaches 16 while req2 is pending -> timeout stays 0, GAP, then gnt=4'b0100.
